// File: rtl/muldiv_pkg.sv
// Shared types and op-decode helpers for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} md_state_e;

  typedef enum logic {STEP_MUL, STEP_DIV} md_step_e;

  function automatic logic is_div(md_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_rem(md_op_e op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  function automatic logic a_signed(md_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic b_signed(md_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response handshake bundle between the execute stage and the muldiv unit.
interface muldiv_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  import muldiv_pkg::*;

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  md_op_e           in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_res;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  modport master (
    output flush, in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_res, out_tag, busy
  );

  modport slave (
    input  flush, in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_res, out_tag, busy
  );

endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, shift/trial-subtract for restoring divide.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  md_step_e           i_mode,
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_opnd,
  output logic [2*WIDTH-1:0] o_acc
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_rem_sh;
  logic [WIDTH:0] w_diff;

  // Divide: shifted partial remainder is < 2*divisor, so WIDTH+1 bits hold it and its borrow.
  always_comb begin
    w_sum    = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + {1'b0, i_opnd};
    w_rem_sh = i_acc[2*WIDTH-1:WIDTH-1];
    w_diff   = w_rem_sh - {1'b0, i_opnd};
    o_acc    = i_acc;
    if (i_mode == STEP_MUL) begin
      if (i_acc[0]) o_acc = {w_sum, i_acc[WIDTH-1:1]};
      else          o_acc = {1'b0, i_acc[2*WIDTH-1:1]};
    end else begin
      if (w_diff[WIDTH]) o_acc = {w_rem_sh[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
      else               o_acc = {w_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MUL/MULH*/DIV*/REM* unit: magnitude datapath with sign fixup, one op in flight.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input logic     clk,
  input logic     rst_n,
  muldiv_if.slave md
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  md_state_e          r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_valid;
  logic [WIDTH-1:0]   r_res;
  logic [TAG_W-1:0]   r_tag;
  md_op_e             r_op;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;

  logic               w_accept;
  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic               w_div0;
  logic               w_ovf;
  logic               w_special;
  logic [WIDTH-1:0]   w_spec_res;
  md_step_e           w_mode;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_fix_res;

  assign w_accept = md.in_valid && (r_state == IDLE) && !md.flush;
  assign w_sa     = a_signed(md.in_op) && md.in_a[WIDTH-1];
  assign w_sb     = b_signed(md.in_op) && md.in_b[WIDTH-1];
  assign w_mag_a  = w_sa ? ('0 - md.in_a) : md.in_a;
  assign w_mag_b  = w_sb ? ('0 - md.in_b) : md.in_b;

  assign w_div0    = (md.in_b == '0);
  assign w_ovf     = (md.in_op inside {OP_DIV, OP_REM}) && (md.in_a == MIN_VAL) && (&md.in_b);
  assign w_special = is_div(md.in_op) && (w_div0 || w_ovf);

  always_comb begin
    w_spec_res = '0;
    if (w_div0) w_spec_res = is_rem(md.in_op) ? md.in_a : '1;
    else        w_spec_res = is_rem(md.in_op) ? '0 : MIN_VAL;
  end

  assign w_mode = is_div(r_op) ? STEP_DIV : STEP_MUL;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_mode (w_mode),
    .i_acc  (r_acc),
    .i_opnd (r_opnd),
    .o_acc  (w_acc_nxt)
  );

  // Sign fixup: quotient/product take the xor of operand signs, remainder the dividend sign.
  assign w_prod = r_neg_q ? ('0 - r_acc) : r_acc;
  assign w_quo  = r_neg_q ? ('0 - r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_r ? ('0 - r_acc[2*WIDTH-1:WIDTH]) : r_acc[2*WIDTH-1:WIDTH];

  always_comb begin
    w_fix_res = '0;
    case (r_op)
      OP_MUL:                      w_fix_res = w_prod[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_fix_res = w_prod[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:             w_fix_res = w_quo;
      default:                     w_fix_res = w_rem;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_res   <= '0;
      r_tag   <= '0;
    end else if (md.flush) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_res   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_tag <= md.in_tag;
            if (w_special) begin
              r_res   <= w_spec_res;
              r_valid <= 1'b1;
              r_state <= DONE;
            end else begin
              r_cnt   <= CW'(WIDTH - 1);
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          if (r_cnt == '0) r_state <= FIX;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        FIX: begin
          r_res   <= w_fix_res;
          r_valid <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          if (md.out_ready) begin
            r_valid <= 1'b0;
            r_res   <= '0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Datapath registers carry no reset; they are always loaded at accept before use.
  always_ff @(posedge clk) begin
    if (w_accept && !w_special) begin
      r_op    <= md.in_op;
      r_neg_q <= w_sa ^ w_sb;
      r_neg_r <= w_sa;
      r_acc   <= is_div(md.in_op) ? {{WIDTH{1'b0}}, w_mag_a} : {{WIDTH{1'b0}}, w_mag_b};
      r_opnd  <= is_div(md.in_op) ? w_mag_b : w_mag_a;
    end else if (r_state == CALC) begin
      r_acc <= w_acc_nxt;
    end
  end

  assign md.in_ready  = (r_state == IDLE);
  assign md.busy      = (r_state != IDLE);
  assign md.out_valid = r_valid;
  assign md.out_res   = r_res;
  assign md.out_tag   = r_tag;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=32) with an expected-result queue.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  muldiv_if #(.WIDTH(32), .TAG_W(5)) md ();

  muldiv_unit #(.WIDTH(32), .TAG_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .md    (md)
  );

  initial forever #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb64;
    logic signed [63:0] ub;
    logic [63:0]        p;
    sa   = {{32{a[31]}}, a};
    sb64 = {{32{b[31]}}, b};
    ub   = {32'b0, b};
    p    = '0;
    case (op)
      OP_MUL:    begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      OP_MULH:   begin p = sa * sb64;               return p[63:32]; end
      OP_MULHSU: begin p = sa * ub;                 return p[63:32]; end
      OP_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      OP_DIV: begin
        if (b == 32'd0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return 32'($signed(a) / $signed(b));
      end
      OP_REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        return 32'($signed(a) % $signed(b));
      end
      OP_DIVU: return (b == 32'd0) ? 32'hFFFFFFFF : a / b;
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat_of(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
    if (op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU} && b == 32'd0) return 1;
    if (op inside {OP_DIV, OP_REM} && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return 34;
  endfunction

  task automatic accept(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag);
    int n = 0;
    while (!md.in_ready && n < 100) begin tick(); n++; end
    chk("in_ready_before_issue", 32'(md.in_ready), 32'd1);
    md.in_valid = 1'b1;
    md.in_op    = op;
    md.in_a     = a;
    md.in_b     = b;
    md.in_tag   = tag;
    tick();
    md.in_valid = 1'b0;
    md.in_a     = $urandom;
    md.in_b     = $urandom;
    md.in_tag   = 5'($urandom);
  endtask

  task automatic issue(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] exp, input int lat);
    exp_t e;
    accept(op, a, b, tag);
    e.res = exp;
    e.tag = tag;
    e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic collect(input string name, input int hold);
    exp_t e;
    int   cyc = 1;
    logic stable = 1'b1;
    e = sb.pop_front();
    while (!md.out_valid && cyc < 200) begin tick(); cyc++; end
    chk({name, "_valid"}, 32'(md.out_valid), 32'd1);
    chk({name, "_res"}, md.out_res, e.res);
    chk({name, "_tag"}, 32'(md.out_tag), 32'(e.tag));
    chk({name, "_latency"}, 32'(cyc), 32'(e.lat));
    for (int i = 0; i < hold; i++) begin
      tick();
      if (md.out_res !== e.res || md.out_tag !== e.tag || md.in_ready !== 1'b0 ||
          md.out_valid !== 1'b1) stable = 1'b0;
    end
    if (hold > 0) chk({name, "_held_stable"}, 32'(stable), 32'd1);
    md.out_ready = 1'b1;
    tick();
    md.out_ready = 1'b0;
    chk({name, "_in_ready_after"}, 32'(md.in_ready), 32'd1);
    chk({name, "_res_cleared"}, md.out_res, 32'd0);
  endtask

  initial begin
    logic        seen;
    logic [31:0] ra;
    logic [31:0] rb;
    md_op_e      rop;
    md.flush = 1'b0; md.in_valid = 1'b0; md.in_op = OP_MUL;
    md.in_a = '0; md.in_b = '0; md.in_tag = '0; md.out_ready = 1'b0;

    #1 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 32'(md.in_ready), 32'd1);
    chk("rst_out_valid", 32'(md.out_valid), 32'd0);
    chk("rst_busy", 32'(md.busy), 32'd0);
    chk("rst_out_res", md.out_res, 32'd0);
    chk("rst_out_tag", 32'(md.out_tag), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    issue(OP_MUL, 32'd7, 32'hFFFFFFFD, 5'd1, 32'hFFFFFFEB, 34);        collect("mul", 0);
    issue(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE, 34); collect("mulhu", 0);
    issue(OP_MULH, 32'h80000000, 32'h80000000, 5'd3, 32'h40000000, 34); collect("mulh", 0);
    issue(OP_MULHSU, 32'hFFFFFFFF, 32'd2, 5'd4, 32'hFFFFFFFF, 34);      collect("mulhsu", 0);
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 5'd5, 32'hFFFFFFFD, 34);         collect("div", 0);
    issue(OP_REM, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFF, 34);         collect("rem", 0);
    issue(OP_DIVU, 32'd100, 32'd7, 5'd7, 32'd14, 34);                   collect("divu", 0);
    issue(OP_REMU, 32'd100, 32'd7, 5'd8, 32'd2, 34);                    collect("remu", 0);
    issue(OP_DIV, 32'd5, 32'd0, 5'd9, 32'hFFFFFFFF, 1);                 collect("div_by0", 0);
    issue(OP_REM, 32'd5, 32'd0, 5'd10, 32'd5, 1);                       collect("rem_by0", 0);
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, 1);  collect("div_ovf", 0);
    issue(OP_REM, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'd0, 1);         collect("rem_ovf", 0);

    issue(OP_MUL, 32'd1234, 32'd5678, 5'd13, 32'd7006652, 34);          collect("backpressure", 10);
    issue(OP_DIVU, 32'd1000, 32'd10, 5'd14, 32'd100, 34);               collect("back_to_back", 0);

    for (int i = 0; i < 6; i++) begin
      rop = md_op_e'(3'($urandom_range(0, 7)));
      ra  = $urandom;
      rb  = (i == 5) ? 32'd3 : $urandom;
      issue(rop, ra, rb, 5'(20 + i), model(rop, ra, rb), lat_of(rop, ra, rb));
      collect("random_op", 0);
    end

    accept(OP_MULHU, 32'hDEADBEEF, 32'h12345678, 5'd30);
    repeat (9) tick();
    md.flush = 1'b1;
    tick();
    md.flush = 1'b0;
    chk("flush_in_ready", 32'(md.in_ready), 32'd1);
    chk("flush_busy", 32'(md.busy), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (md.out_valid !== 1'b0) seen = 1'b1;
    end
    chk("flush_no_result", 32'(seen), 32'd0);

    md.in_valid = 1'b1; md.in_op = OP_MUL; md.in_a = 32'd3; md.in_b = 32'd3;
    md.flush = 1'b1;
    tick();
    md.in_valid = 1'b0; md.flush = 1'b0;
    chk("flush_blocks_accept", 32'(md.busy), 32'd0);

    accept(OP_DIV, 32'd99, 32'd4, 5'd17);
    repeat (5) tick();
    rst_n = 1'b0;
    #2;
    chk("async_rst_in_ready", 32'(md.in_ready), 32'd1);
    chk("async_rst_busy", 32'(md.busy), 32'd0);
    chk("async_rst_out_valid", 32'(md.out_valid), 32'd0);
    chk("async_rst_out_res", md.out_res, 32'd0);
    chk("async_rst_out_tag", 32'(md.out_tag), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    issue(OP_REM, 32'd99, 32'd4, 5'd18, 32'd3, 34);                     collect("after_reset", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
